fifo_rd_stream: RTL

Read-side drain stage placed directly downstream of the asynchronous FIFO top, in the read clock domain. It issues `pop` to the FIFO whenever it has room, captures the FIFO's registered read data one cycle later into a small skid buffer, and presents the words on a valid/ready stream interface at full throughput. A saturating counter of delivered words is provided for bring-up and scoreboard cross-checks.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_rd_stream_if.sv | 22 ++
 rtl/fifo_rd_stream_skid_buf.sv | 49 ++++
 rtl/fifo_rd_stream.sv | 66 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and defaults for the FIFO read-side drain stage.
package fifo_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SKID_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the drain stage.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W
);
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    // master: the drain stage (pops the FIFO, sources the stream)
    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_pop, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_pop, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// Small circular skid buffer: write side fed by FIFO read data, read side is valid/ready.
module skid_buf #(
    parameter  int unsigned DATA_W     = fifo_pkg::DATA_W,
    parameter  int unsigned SKID_DEPTH = fifo_pkg::SKID_DEPTH,
    localparam int unsigned AW         = $clog2(SKID_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              fire,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign fire     = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // simultaneous write and fire leave the occupancy unchanged
            case ({wr_en, fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain stage: pops the async FIFO ahead of demand and streams words out
// through a skid buffer; also keeps a saturating delivered-word counter.
module fifo_rd_stream #(
    parameter int unsigned DATA_W     = fifo_pkg::DATA_W,
    parameter int unsigned SKID_DEPTH = fifo_pkg::SKID_DEPTH,
    parameter int unsigned CNT_W      = fifo_pkg::CNT_W
) (
    input  logic             rdclk,
    input  logic             rd_rst,
    fifo_rd_stream_if.master bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);

    localparam int unsigned AW      = $clog2(SKID_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(SKID_DEPTH);

    logic        inflight;
    logic        fire;
    logic [AW:0] count;
    logic [AW:0] occ;

    // Words already buffered plus the one returning this cycle must leave room,
    // so pop never depends on m_ready.
    assign occ = count + {{AW{1'b0}}, inflight};

    always_comb begin
        bus.fifo_pop = rd_rst && !bus.fifo_empty && (occ < DEPTH_C);
    end

    always_ff @(posedge rdclk) begin
        if (!rd_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_pop;
        end
    end

    skid_buf #(
        .DATA_W     (DATA_W),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk      (rdclk),
        .rst_n    (rd_rst),
        .wr_en    (inflight),
        .wr_data  (bus.fifo_data),
        .rd_ready (bus.m_ready),
        .rd_valid (bus.m_valid),
        .rd_data  (bus.m_data),
        .fire     (fire),
        .count    (count)
    );

    // clear takes priority, so a fire in the clear cycle is not counted
    always_ff @(posedge rdclk) begin
        if (!rd_rst || clr_cnt) begin
            word_cnt <= '0;
        end else if (fire && (word_cnt != '1)) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    assign busy = (count != '0) || inflight;

endmodule
